datamover_rd_sched: RTL and testbench
=====================================

DATAMOVER_RD_SCHED -- requirements
Module: datamover_rd_sched

Interface
REQ-001 Parameter CHUNK_BYTES, default 256, SHALL set the maximum bytes per MM2S command (legal 1..4096).
REQ-002 Parameter MAX_OUT, default 2, SHALL set the maximum outstanding MM2S commands (legal 1..15).
REQ-003 Clock and reset SHALL be one clock and an asynchronous, active-high reset, named clk and rst.
REQ-004 The block SHALL provide the following ports:
- clk, in, 1: clock.
- rst, in, 1: async active-high reset.
- i_req_valid, in, 1: transfer request valid.
- o_req_ready, out, 1: request accepted when high with i_req_valid.
- i_req_addr, in, 32: transfer start byte address.
- i_req_bytes, in, 24: transfer total bytes.
- o_mm2s_rd_cmd_tdata, out, 72: MM2S command word.
- o_mm2s_rd_cmd_tvalid, out, 1: command valid.
- i_mm2s_rd_cmd_tready, in, 1: command ready.
- i_mm2s_rd_tvalid, in, 1: read stream valid (monitor only).
- i_mm2s_rd_tready, in, 1: read stream ready from consumer (monitor only).
- i_mm2s_rd_tlast, in, 1: read stream last (monitor only).
- o_busy, out, 1: transfer in progress.
- o_done, out, 1: one-cycle transfer-complete pulse.
- o_err, out, 1: sticky unexpected-tlast flag.

Function
REQ-005 The FSM SHALL have states IDLE, CMD, WAIT, DRAIN and DONE; o_req_ready=1 only in IDLE; o_busy=1 in every state except IDLE.
REQ-006 On i_req_valid&o_req_ready, the block SHALL latch cur_addr=i_req_addr and remaining=i_req_bytes, clear o_err, and go to DONE if i_req_bytes==0, else to CMD.
REQ-007 Timing: a request accepted in cycle N SHALL produce o_mm2s_rd_cmd_tvalid=1 in cycle N+1.
REQ-008 Chunk size SHALL be chunk = min(remaining, CHUNK_BYTES, 4096 - cur_addr[11:0]), so no command crosses a 4 KiB boundary.
REQ-009 In CMD, tvalid=1 and tdata SHALL be {8'd0, cur_addr, 1'b0, 1'b1, 7'd1, chunk zero-extended to 23 bits}: bits [63:32]=addr, bit 30=EOF=1, bits [29:23]=1, bits [22:0]=BTT.
REQ-010 tdata and tvalid SHALL be held stable while tvalid=1 and i_mm2s_rd_cmd_tready=0; in all other states tvalid=0 and tdata=0.
REQ-011 On a command handshake, the block SHALL update cur_addr+=chunk, remaining-=chunk and outstanding+=1 (32-bit address arithmetic wraps modulo 2^32).
REQ-012 A completion SHALL be defined as i_mm2s_rd_tvalid&i_mm2s_rd_tready&i_mm2s_rd_tlast, and SHALL decrement outstanding when outstanding>0.
REQ-013 A handshake and a completion in the same cycle SHALL leave outstanding unchanged.
REQ-014 After a handshake in CMD, the next state SHALL be:
- DRAIN if the updated remaining==0;
- else WAIT if the updated outstanding==MAX_OUT;
- else CMD.
REQ-015 WAIT SHALL go to CMD on the first cycle outstanding<MAX_OUT, including the completion cycle itself.
REQ-016 DRAIN SHALL go to DONE when the updated outstanding==0.
REQ-017 DONE SHALL assert o_done=1 for exactly one cycle, then return to IDLE.
REQ-018 A completion with outstanding==0, in any state, SHALL set o_err=1 and leave outstanding at 0; o_err SHALL stay set until the next request is accepted.
REQ-019 Counter widths SHALL be: remaining 24 bits, chunk 13 bits, outstanding 4 bits.

Reset
REQ-020 rst=1 SHALL asynchronously force the following, and rst mid-transfer SHALL abandon the transfer with no o_done:
- state=IDLE, outstanding=0, remaining=0, cur_addr=0;
- o_mm2s_rd_cmd_tvalid=0, o_mm2s_rd_cmd_tdata=0;
- o_busy=0, o_done=0, o_err=0;
- o_req_ready=1.

Verification
REQ-021 Multi-chunk transfer (CHUNK 256, MAX_OUT 2, addr 0x1000_0000, bytes 600):
- commands BTT 256 @0x1000_0000 and BTT 256 @0x1000_0100;
- WAIT until the first tlast, then BTT 88 @0x1000_0200;
- o_done one cycle after DRAIN sees the 3rd tlast.
REQ-022 4 KiB crossing (addr 0x0000_0FC0, bytes 256) -> commands BTT 64 @0x0000_0FC0, then BTT 192 @0x0000_1000.
REQ-023 Zero length (bytes 0) -> o_done=1 in cycle N+2 after acceptance in cycle N; no tvalid ever asserted; o_busy=1 for exactly 1 cycle.
REQ-024 Backpressure and simultaneous events:
- tready held 0 for 5 cycles -> tdata constant and tvalid=1 throughout;
- a handshake coinciding with a completion at outstanding==MAX_OUT-1 -> outstanding unchanged, state stays CMD.
REQ-025 Stray tlast and recovery:
- completion while in IDLE -> o_err=1 next cycle, outstanding stays 0;
- the next accepted request -> o_err=0.
REQ-026 rst pulse during WAIT with outstanding=2 -> state IDLE immediately; o_mm2s_rd_cmd_tvalid=0; a following completion sets o_err=1.

Source files
------------

// File: rtl/datamover_rd_sched_if.sv
// Request, MM2S command and MM2S read-stream monitor signals of the read scheduler.
// The scheduler uses the slave modport; the requester/datamover side uses master.
interface datamover_rd_sched_if;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [31:0] i_req_addr;
   logic [23:0] i_req_bytes;
   logic [71:0] o_mm2s_rd_cmd_tdata;
   logic        o_mm2s_rd_cmd_tvalid;
   logic        i_mm2s_rd_cmd_tready;
   logic        i_mm2s_rd_tvalid;
   logic        i_mm2s_rd_tready;
   logic        i_mm2s_rd_tlast;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   modport slave (
      input  i_req_valid, i_req_addr, i_req_bytes, i_mm2s_rd_cmd_tready,
             i_mm2s_rd_tvalid, i_mm2s_rd_tready, i_mm2s_rd_tlast,
      output o_req_ready, o_mm2s_rd_cmd_tdata, o_mm2s_rd_cmd_tvalid,
             o_busy, o_done, o_err
   );

   modport master (
      output i_req_valid, i_req_addr, i_req_bytes, i_mm2s_rd_cmd_tready,
             i_mm2s_rd_tvalid, i_mm2s_rd_tready, i_mm2s_rd_tlast,
      input  o_req_ready, o_mm2s_rd_cmd_tdata, o_mm2s_rd_cmd_tvalid,
             o_busy, o_done, o_err
   );
endinterface

// File: rtl/datamover_rd_sched.sv
// Splits a transfer request into MM2S read commands of at most CHUNK_BYTES that never
// cross a 4 KiB page, keeping at most MAX_OUT commands outstanding until their tlast.
module datamover_rd_sched #(
   parameter int CHUNK_BYTES = 256,
   parameter int MAX_OUT     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   datamover_rd_sched_if.slave   bus
);

   localparam logic [12:0] CHUNK_MAX = 13'(CHUNK_BYTES);
   localparam logic [3:0]  OUT_MAX   = 4'(MAX_OUT);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_WAIT, S_DRAIN, S_DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] cur_addr;
   logic [23:0] remaining, rem_nxt;
   logic [3:0]  outstanding, out_nxt;
   logic [12:0] page_left, chunk;
   logic        err_q, done_q;
   logic        accept, hs, cpl, dec, stray;

   assign accept = bus.i_req_valid && (state == S_IDLE);
   assign hs     = (state == S_CMD) && bus.i_mm2s_rd_cmd_tready;
   assign cpl    = bus.i_mm2s_rd_tvalid && bus.i_mm2s_rd_tready && bus.i_mm2s_rd_tlast;
   assign dec    = cpl && (outstanding != 4'd0);
   assign stray  = cpl && (outstanding == 4'd0);

   always_comb begin
      page_left = 13'd4096 - {1'b0, cur_addr[11:0]};
      chunk     = CHUNK_MAX;
      if (page_left < chunk)
         chunk = page_left;
      if (remaining < {11'd0, chunk})
         chunk = remaining[12:0];
      rem_nxt = hs ? (remaining - {11'd0, chunk}) : remaining;
      // A handshake and a completion together cancel out.
      case ({hs, dec})
         2'b10:   out_nxt = outstanding + 4'd1;
         2'b01:   out_nxt = outstanding - 4'd1;
         default: out_nxt = outstanding;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.i_req_valid)
                     state_nxt = (bus.i_req_bytes == 24'd0) ? S_DONE : S_CMD;
         S_CMD:   if (hs) begin
                     if (rem_nxt == 24'd0)       state_nxt = S_DRAIN;
                     else if (out_nxt == OUT_MAX) state_nxt = S_WAIT;
                  end
         S_WAIT:  if (out_nxt < OUT_MAX)   state_nxt = S_CMD;
         S_DRAIN: if (out_nxt == 4'd0)     state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.o_req_ready          = (state == S_IDLE);
      bus.o_busy               = (state != S_IDLE);
      bus.o_mm2s_rd_cmd_tvalid = (state == S_CMD);
      bus.o_mm2s_rd_cmd_tdata  = '0;
      if (state == S_CMD)
         bus.o_mm2s_rd_cmd_tdata = {8'd0, cur_addr, 1'b0, 1'b1, 7'd1, 10'd0, chunk};
      bus.o_done               = done_q;
      bus.o_err                = err_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_addr    <= '0;
         remaining   <= '0;
         outstanding <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         outstanding <= out_nxt;
         if (accept) begin
            cur_addr  <= bus.i_req_addr;
            remaining <= bus.i_req_bytes;
         end else if (hs) begin
            cur_addr  <= cur_addr + {19'd0, chunk};
            remaining <= rem_nxt;
         end
         if (accept)
            err_q <= 1'b0;
         else if (stray)
            err_q <= 1'b1;
         // Registered so the pulse lands the cycle after DONE is entered.
         done_q <= (state == S_DONE);
      end
   end

endmodule

// File: tb/tb_datamover_rd_sched.sv
// Scoreboard bench for datamover_rd_sched: expected command words are queued when a
// request is issued and compared by a monitor on every command handshake.
module tb_datamover_rd_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   datamover_rd_sched_if bus ();
   datamover_rd_sched #(.CHUNK_BYTES(256), .MAX_OUT(2)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk = 0;
   int n_err = 0;
   logic [71:0] exp_q[$];

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] cmd_word(input logic [31:0] a, input logic [22:0] btt);
      return {8'd0, a, 1'b0, 1'b1, 7'd1, btt};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Command scoreboard: each handshake must match the next queued word.
   always @(negedge clk) begin
      if (!rst && bus.o_mm2s_rd_cmd_tvalid && bus.i_mm2s_rd_cmd_tready) begin
         if (exp_q.size() == 0)
            chk("cmd_extra", bus.o_mm2s_rd_cmd_tdata, 72'd0);
         else
            chk("cmd_word", bus.o_mm2s_rd_cmd_tdata, exp_q.pop_front());
      end
   end

   task automatic req(input logic [31:0] a, input logic [23:0] b);
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = a;
      bus.i_req_bytes = b;
      tick();
      bus.i_req_valid = 1'b0;
   endtask

   task automatic set_cpl(input logic v);
      bus.i_mm2s_rd_tvalid = v;
      bus.i_mm2s_rd_tready = v;
      bus.i_mm2s_rd_tlast  = v;
   endtask

   task automatic cpl_pulse();
      set_cpl(1'b1);
      tick();
      set_cpl(1'b0);
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (!bus.o_done && k < 50) begin
         tick();
         k++;
      end
      chk(tag, {71'd0, bus.o_done}, 72'd1);
      tick();
      chk({tag, "_width"}, {71'd0, bus.o_done}, 72'd0);
   endtask

   initial begin
      bus.i_req_valid = 1'b0;
      bus.i_req_addr  = '0;
      bus.i_req_bytes = '0;
      bus.i_mm2s_rd_cmd_tready = 1'b1;
      set_cpl(1'b0);
      #12;
      chk("rst_ready", {71'd0, bus.o_req_ready}, 72'd1);
      chk("rst_busy",  {71'd0, bus.o_busy}, 72'd0);
      chk("rst_tvalid", {71'd0, bus.o_mm2s_rd_cmd_tvalid}, 72'd0);
      chk("rst_tdata", bus.o_mm2s_rd_cmd_tdata, 72'd0);
      chk("rst_done_err", {70'd0, bus.o_done, bus.o_err}, 72'd0);
      rst = 1'b0;
      tick();

      // Multi-chunk: two commands, WAIT, third command after first tlast.
      exp_q.push_back(cmd_word(32'h1000_0000, 23'd256));
      exp_q.push_back(cmd_word(32'h1000_0100, 23'd256));
      exp_q.push_back(cmd_word(32'h1000_0200, 23'd88));
      req(32'h1000_0000, 24'd600);
      chk("mc_tvalid_n1", {71'd0, bus.o_mm2s_rd_cmd_tvalid}, 72'd1);
      chk("mc_busy", {71'd0, bus.o_busy}, 72'd1);
      tick();
      tick();
      chk("mc_wait_tvalid", {71'd0, bus.o_mm2s_rd_cmd_tvalid}, 72'd0);
      tick();
      chk("mc_wait_hold", {71'd0, bus.o_mm2s_rd_cmd_tvalid}, 72'd0);
      cpl_pulse();
      chk("mc_resume", bus.o_mm2s_rd_cmd_tdata, cmd_word(32'h1000_0200, 23'd88));
      tick();
      chk("mc_drain_tvalid", {71'd0, bus.o_mm2s_rd_cmd_tvalid}, 72'd0);
      cpl_pulse();
      chk("mc_drain_nodone", {70'd0, bus.o_done, bus.o_busy}, 72'd1);
      cpl_pulse();
      wait_done("mc_done");
      chk("mc_idle", {70'd0, bus.o_busy, bus.o_err}, 72'd0);

      // 4 KiB crossing.
      exp_q.push_back(cmd_word(32'h0000_0FC0, 23'd64));
      exp_q.push_back(cmd_word(32'h0000_1000, 23'd192));
      req(32'h0000_0FC0, 24'd256);
      tick();
      tick();
      cpl_pulse();
      cpl_pulse();
      wait_done("x4k_done");

      // Zero length: busy one cycle, done in N+2, no command.
      req(32'h0000_8000, 24'd0);
      chk("z_busy_n1", {70'd0, bus.o_busy, bus.o_done}, 72'd2);
      chk("z_tvalid_n1", {71'd0, bus.o_mm2s_rd_cmd_tvalid}, 72'd0);
      tick();
      chk("z_done_n2", {70'd0, bus.o_busy, bus.o_done}, 72'd1);
      tick();
      chk("z_done_off", {70'd0, bus.o_busy, bus.o_done}, 72'd0);

      // Backpressure, then handshake coinciding with a completion at outstanding==1.
      bus.i_mm2s_rd_cmd_tready = 1'b0;
      exp_q.push_back(cmd_word(32'h2000_0000, 23'd256));
      exp_q.push_back(cmd_word(32'h2000_0100, 23'd256));
      exp_q.push_back(cmd_word(32'h2000_0200, 23'd256));
      req(32'h2000_0000, 24'd768);
      for (int i = 0; i < 5; i++) begin
         chk("bp_tvalid", {71'd0, bus.o_mm2s_rd_cmd_tvalid}, 72'd1);
         chk("bp_tdata", bus.o_mm2s_rd_cmd_tdata, cmd_word(32'h2000_0000, 23'd256));
         tick();
      end
      bus.i_mm2s_rd_cmd_tready = 1'b1;
      tick();
      cpl_pulse();
      chk("sim_stay_cmd", {71'd0, bus.o_mm2s_rd_cmd_tvalid}, 72'd1);
      chk("sim_next_cmd", bus.o_mm2s_rd_cmd_tdata, cmd_word(32'h2000_0200, 23'd256));
      tick();
      chk("sim_drain", {71'd0, bus.o_mm2s_rd_cmd_tvalid}, 72'd0);
      cpl_pulse();
      chk("sim_drain_busy", {70'd0, bus.o_busy, bus.o_done}, 72'd2);
      cpl_pulse();
      wait_done("sim_done");

      // Stray tlast in IDLE and recovery.
      cpl_pulse();
      chk("stray_err", {71'd0, bus.o_err}, 72'd1);
      exp_q.push_back(cmd_word(32'h0000_0040, 23'd16));
      req(32'h0000_0040, 24'd16);
      chk("stray_clear", {71'd0, bus.o_err}, 72'd0);
      tick();
      cpl_pulse();
      chk("stray_one_cpl", {71'd0, bus.o_err}, 72'd0);
      wait_done("stray_done");

      // Reset during WAIT abandons the transfer.
      exp_q.push_back(cmd_word(32'h3000_0000, 23'd256));
      exp_q.push_back(cmd_word(32'h3000_0100, 23'd256));
      req(32'h3000_0000, 24'd1024);
      tick();
      tick();
      chk("rw_wait", {70'd0, bus.o_busy, bus.o_mm2s_rd_cmd_tvalid}, 72'd2);
      #2 rst = 1'b1;
      #1;
      chk("rw_async", {69'd0, bus.o_req_ready, bus.o_busy, bus.o_mm2s_rd_cmd_tvalid}, 72'd4);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rw_no_done", {70'd0, bus.o_done, bus.o_mm2s_rd_cmd_tvalid}, 72'd0);
         tick();
      end
      cpl_pulse();
      chk("rw_stray_err", {71'd0, bus.o_err}, 72'd1);

      chk("sb_empty", 72'(exp_q.size()), 72'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule
